// File: rtl/stack_mc_controller.sv
// Multi-cycle control FSM for the stack-based MIPS datapath.
// Sequences fetch/decode/memory/stack phases and decodes per-state control strobes.
module stack_mc_controller (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [2:0] opcode_i,
  input  logic       tos_zero_i,
  output logic       pc_ld_o,
  output logic       ir_ld_o,
  output logic       mdr_ld_o,
  output logic       a_ld_o,
  output logic       b_ld_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       iord_o,
  output logic       push_o,
  output logic       pop_o,
  output logic       tos_o,
  output logic       stack_src_o,
  output logic       pc_src_o,
  output logic [1:0] alu_op_o,
  output logic       done_o,
  output logic [3:0] state_o
);

  // state | meaning
  // FETCH | read instruction at PC, load IR, advance PC
  // DECODE| dispatch on opcode; pops first operand, JMP/JZ finish here
  // POPB  | pop second operand into B
  // ALU2  | push A op B
  // ALU1  | push NOT A
  // MEMRD | read memory at IR address into MDR
  // PUSHM | push MDR
  // MEMWR | write A to memory at IR address
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_POPB   = 4'd2,
    S_ALU2   = 4'd3,
    S_ALU1   = 4'd4,
    S_MEMRD  = 4'd5,
    S_PUSHM  = 4'd6,
    S_MEMWR  = 4'd7
  } state_e;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_PUSH = 3'b100;
  localparam logic [2:0] OP_POP  = 3'b101;
  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_JZ   = 3'b111;

  state_e state_q, state_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = S_FETCH;
    pc_ld_o     = 1'b0;
    ir_ld_o     = 1'b0;
    mdr_ld_o    = 1'b0;
    a_ld_o      = 1'b0;
    b_ld_o      = 1'b0;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    iord_o      = 1'b0;
    push_o      = 1'b0;
    pop_o       = 1'b0;
    tos_o       = 1'b0;
    stack_src_o = 1'b0;
    pc_src_o    = 1'b0;
    alu_op_o    = 2'b00;
    done_o      = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read_o = 1'b1;
        ir_ld_o    = 1'b1;
        pc_ld_o    = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        case (opcode_i)
          OP_ADD, OP_SUB, OP_AND: begin
            pop_o   = 1'b1;
            a_ld_o  = 1'b1;
            state_d = S_POPB;
          end
          OP_NOT: begin
            pop_o   = 1'b1;
            a_ld_o  = 1'b1;
            state_d = S_ALU1;
          end
          OP_PUSH: begin
            state_d = S_MEMRD;
          end
          OP_POP: begin
            pop_o   = 1'b1;
            a_ld_o  = 1'b1;
            state_d = S_MEMWR;
          end
          OP_JMP: begin
            pc_ld_o  = 1'b1;
            pc_src_o = 1'b1;
            done_o   = 1'b1;
            state_d  = S_FETCH;
          end
          OP_JZ: begin
            // Peek only; the stack is left untouched whether or not the branch is taken.
            tos_o    = 1'b1;
            pc_ld_o  = tos_zero_i;
            pc_src_o = tos_zero_i;
            done_o   = 1'b1;
            state_d  = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_POPB: begin
        pop_o   = 1'b1;
        b_ld_o  = 1'b1;
        state_d = S_ALU2;
      end
      S_ALU2: begin
        alu_op_o    = opcode_i[1:0];
        push_o      = 1'b1;
        stack_src_o = 1'b1;
        done_o      = 1'b1;
        state_d     = S_FETCH;
      end
      S_ALU1: begin
        alu_op_o    = 2'b11;
        push_o      = 1'b1;
        stack_src_o = 1'b1;
        done_o      = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMRD: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
        mdr_ld_o   = 1'b1;
        state_d    = S_PUSHM;
      end
      S_PUSHM: begin
        push_o  = 1'b1;
        done_o  = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWR: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
        done_o      = 1'b1;
        state_d     = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset kills every strobe combinationally so an in-flight write or push cannot finish.
    if (!rst_ni) begin
      pc_ld_o     = 1'b0;
      ir_ld_o     = 1'b0;
      mdr_ld_o    = 1'b0;
      a_ld_o      = 1'b0;
      b_ld_o      = 1'b0;
      mem_read_o  = 1'b0;
      mem_write_o = 1'b0;
      iord_o      = 1'b0;
      push_o      = 1'b0;
      pop_o       = 1'b0;
      tos_o       = 1'b0;
      stack_src_o = 1'b0;
      pc_src_o    = 1'b0;
      alu_op_o    = 2'b00;
      done_o      = 1'b0;
    end
  end

  assign state_o = state_q;

endmodule

// File: doc/stack_mc_controller.md
# stack_mc_controller

Multi-cycle control unit for the stack-based MIPS datapath. Registered FSM that sequences one instruction at a time through fetch, decode, memory and stack phases. Drives the load enables of the datapath's load-enable registers (PC, IR, MDR, A, B), memory read/write, stack push/pop, and mux/ALU selects. Sits beside the datapath and receives only the IR opcode and the stack-top-zero flag.

## Interface
- No parameters; 8-bit instruction format fixed: opcode = ir[7:5], address = ir[4:0] (address routing is in the datapath).
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- opcode  in  3  ir[7:5]: 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 PUSH, 101 POP, 110 JMP, 111 JZ
- tos_zero  in  1  stack top equals zero (combinational from stack)
- pc_ld, ir_ld, mdr_ld, a_ld, b_ld  out  1 each  register load enables
- mem_read, mem_write  out  1 each  memory strobes
- iord  out  1  memory address select: 0 = PC, 1 = IR address field
- push, pop, tos  out  1 each  stack operations (tos = read top, no pop)
- stack_src  out  1  push data select: 0 = MDR, 1 = ALU result
- pc_src  out  1  PC next select: 0 = PC+1, 1 = IR address field
- alu_op  out  2  00 add, 01 sub, 10 and, 11 not
- done  out  1  high in the last cycle of every instruction
- state  out  4  current state, for debug/verification

## Operation
- Outputs are combinational decodes of the registered state, plus opcode in DECODE and tos_zero for JZ; unlisted outputs are 0.
- States (encoding):
  - FETCH (0): mem_read, iord=0, ir_ld, pc_ld, pc_src=0 -> DECODE.
  - DECODE (1), by opcode:
    - ADD/SUB/AND: pop, a_ld -> POPB.
    - NOT: pop, a_ld -> ALU1.
    - PUSH: no outputs -> MEMRD.
    - POP: pop, a_ld -> MEMWR.
    - JMP: pc_ld, pc_src=1, done -> FETCH.
    - JZ: tos, done, plus pc_ld and pc_src=1 only if tos_zero -> FETCH. The stack is unchanged.
  - POPB (2): pop, b_ld -> ALU2.
  - ALU2 (3): alu_op=opcode[1:0], push, stack_src=1, done -> FETCH. The ALU computes A op B (A = former top).
  - ALU1 (4): alu_op=11, push, stack_src=1, done -> FETCH.
  - MEMRD (5): mem_read, iord=1, mdr_ld -> PUSHM.
  - PUSHM (6): push, stack_src=0, done -> FETCH.
  - MEMWR (7): mem_write, iord=1 (data = A), done -> FETCH.
- Encodings 8–15 are illegal and go to FETCH on the next edge with all outputs 0.
- The opcode input is sampled only in DECODE and ALU2; IR is stable there because ir_ld is asserted only in FETCH.
- push and pop are never asserted in the same cycle. mem_read and mem_write are never asserted in the same cycle.

## Timing
- Reset: rst low -> state=FETCH immediately (async). All outputs are forced to 0 while rst is low, including state=0.
- After rst rises, the FETCH outputs are active in that cycle, and IR/PC load on the first rising edge.
- Instruction latency in cycles, FETCH included:
  - ADD/SUB/AND: 4
  - NOT: 3
  - PUSH: 4
  - POP: 3
  - JMP: 2
  - JZ: 2 (taken or not)
- A new FETCH follows every done cycle with no bubble.
- Reset asserted mid-instruction aborts it: no partial write completes after the asynchronous edge, and restart is from FETCH.
- JZ evaluates tos_zero in the DECODE cycle only; a change in any other cycle is ignored.
- Stack overflow/underflow is not detected here and is the stack's responsibility.

## Test plan
- Reset: hold rst=0 with opcode=100 -> all outputs 0, state=0. Release -> FETCH outputs (mem_read=1, ir_ld=1, pc_ld=1) in the same cycle, state=1 after the edge.
- ADD (opcode 000): state sequence 0,1,2,3,0. pop high in states 1 and 2, push and done high in state 3, alu_op=00 in state 3. Repeat with SUB -> alu_op=01, AND -> alu_op=10.
- PUSH (100) then POP (101): PUSH gives sequence 0,1,5,6 with mdr_ld and iord=1 in state 5 and push with stack_src=0 in state 6. POP gives 0,1,7 with mem_write=1 and iord=1 in state 7. push/pop and mem_read/mem_write are never both high.
- JZ (111): with tos_zero=1 -> pc_ld=1 and pc_src=1 in state 1. With tos_zero=0 -> pc_ld=0. In both cases tos=1, pop=0, done=1, and the next state is 0.
- JMP (110) and NOT (011): JMP takes 2 cycles with pc_src=1 in DECODE. NOT gives 0,1,4 with alu_op=11 and push in state 4. Count done pulses over the mixed program: exactly one per instruction.
- Reset mid-op: pull rst low during state 2 of an ADD -> outputs 0 within the same cycle, no push. After release, execution restarts at state 0.
